// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: run control and decode inputs toward inst_fetch, PC/status back.
// master: the sequencer/decoder side that drives Start, StartAddr and the decode strobes.
// slave : the inst_fetch stage, which drives ProgCtr, Running, Done, CycCnt and Fault.
interface inst_fetch_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 11,
  parameter int unsigned CYC_W = 16
);
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             Stall;
  logic             Halt;
  logic             BranchRel;
  logic             Taken;
  logic [OFF_W-1:0] Target;
  logic             JumpAbs;
  logic [PC_W-1:0]  JumpAddr;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic [CYC_W-1:0] CycCnt;
  logic             Fault;

  modport master (
    output Start, StartAddr, Stall, Halt, BranchRel, Taken, Target, JumpAbs, JumpAddr,
    input  ProgCtr, Running, Done, CycCnt, Fault
  );

  modport slave (
    input  Start, StartAddr, Stall, Halt, BranchRel, Taken, Target, JumpAbs, JumpAddr,
    output ProgCtr, Running, Done, CycCnt, Fault
  );
endinterface

// File: rtl/inst_fetch.sv
// Program counter and fetch sequencer of the 3BC processor.
// Runs a program from StartAddr until Halt, choosing the next PC from
// restart / halt / stall / absolute jump / taken relative branch / increment,
// and counts the cycles spent running (saturating).
// Ports:
//   Clk   - clock, all state on rising edge
//   Reset - synchronous, active-high
//   bus   - inst_fetch_if.slave: Start/StartAddr, decode strobes in;
//           ProgCtr, Running, Done, CycCnt, Fault out (all registered)
// Optional build macro INST_FETCH_BCHK_EN: adds parameter PROG_END and a
// bounds check on jump/branch destinations that ends the run with Fault=1.
// Without it, Fault is held at 0 and destinations wrap modulo 2^PC_W.
module inst_fetch #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 11,
  parameter int unsigned CYC_W = 16
`ifdef INST_FETCH_BCHK_EN
  ,
  parameter int unsigned PROG_END = (2 ** PC_W) - 1
`endif
) (
  input  logic         Clk,
  input  logic         Reset,
  inst_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             fault_q, fault_d;
  logic             running_q, done_q;

  // Relative-branch destination
  logic [PC_W-1:0]  br_pc;
`ifdef INST_FETCH_BCHK_EN
  // Unwrapped destination in PC_W+1-bit signed form for the bounds check
  logic signed [PC_W:0] off_ext;
  logic [PC_W:0]        br_dest;
  logic                 br_oob;
  logic                 jmp_oob;

  always_comb begin
    off_ext = (PC_W+1)'(signed'(bus.Target));
    br_dest = {1'b0, pc_q} + off_ext;
    br_pc   = br_dest[PC_W-1:0];
    br_oob  = br_dest[PC_W] || (br_dest[PC_W-1:0] > PC_W'(PROG_END));
    jmp_oob = bus.JumpAddr > PC_W'(PROG_END);
  end
`else
  always_comb begin
    br_pc = pc_q + PC_W'(signed'(bus.Target));
  end
`endif

  // Next-state and next-output selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    fault_d = fault_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = bus.StartAddr;
          cyc_d   = '0;
          fault_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.Start) begin
          pc_d    = bus.StartAddr;
          cyc_d   = '0;
          fault_d = 1'b0;
        end else begin
          // Every non-restart RUN cycle counts, stalls and halt included
          cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
          if (bus.Halt) begin
            state_d = DONE;
          end else if (bus.Stall) begin
            pc_d = pc_q;
          end else if (bus.JumpAbs) begin
`ifdef INST_FETCH_BCHK_EN
            if (jmp_oob) begin
              state_d = DONE;
              fault_d = 1'b1;
            end else begin
              pc_d = bus.JumpAddr;
            end
`else
            pc_d = bus.JumpAddr;
`endif
          end else if (bus.BranchRel && bus.Taken) begin
`ifdef INST_FETCH_BCHK_EN
            if (br_oob) begin
              state_d = DONE;
              fault_d = 1'b1;
            end else begin
              pc_d = br_pc;
            end
`else
            pc_d = br_pc;
`endif
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cyc_q     <= '0;
      fault_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cyc_q     <= cyc_d;
      fault_q   <= fault_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.ProgCtr = pc_q;
  assign bus.CycCnt  = cyc_q;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;
  assign bus.Fault   = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, sequential fetch, relative branches
// (taken/not taken, negative wrap), PC wrap, stall vs. jump priority,
// halt/done, restart, and reset in the middle of a run.
module tb_inst_fetch;
  localparam int unsigned PC_W  = 10;
  localparam int unsigned OFF_W = 11;
  localparam int unsigned CYC_W = 16;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  inst_fetch_if #(.PC_W(PC_W), .OFF_W(OFF_W), .CYC_W(CYC_W)) bus ();

  inst_fetch #(.PC_W(PC_W), .OFF_W(OFF_W), .CYC_W(CYC_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start     = 1'b0;
    bus.StartAddr = '0;
    bus.Stall     = 1'b0;
    bus.Halt      = 1'b0;
    bus.BranchRel = 1'b0;
    bus.Taken     = 1'b0;
    bus.Target    = '0;
    bus.JumpAbs   = 1'b0;
    bus.JumpAddr  = '0;
  endtask

  task automatic start_at(input logic [PC_W-1:0] addr);
    bus.Start     = 1'b1;
    bus.StartAddr = addr;
    tick();
    bus.Start     = 1'b0;
  endtask

  task automatic jump_to(input logic [PC_W-1:0] addr);
    bus.JumpAbs  = 1'b1;
    bus.JumpAddr = addr;
    tick();
    bus.JumpAbs  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_pc",      32'(bus.ProgCtr), 0);
    chk("rst_running", 32'(bus.Running), 0);
    chk("rst_done",    32'(bus.Done),    0);
    chk("rst_cyc",     32'(bus.CycCnt),  0);
    chk("rst_fault",   32'(bus.Fault),   0);
    Reset = 1'b0;

    // Decode inputs are ignored in IDLE
    bus.JumpAbs  = 1'b1;
    bus.JumpAddr = 10'd100;
    bus.Halt     = 1'b1;
    tick();
    chk("idle_pc",      32'(bus.ProgCtr), 0);
    chk("idle_running", 32'(bus.Running), 0);
    idle_inputs();

    // Start at 370 then three plain cycles
    start_at(10'd370);
    chk("start_pc",      32'(bus.ProgCtr), 370);
    chk("start_running", 32'(bus.Running), 1);
    chk("start_cyc",     32'(bus.CycCnt),  0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", 32'(bus.ProgCtr), 32'(370 + i));
    end
    chk("seq_cyc", 32'(bus.CycCnt), 3);

    // Taken branch -370 from 370 lands on 0; restart resets the counter
    start_at(10'd370);
    chk("restart_cyc", 32'(bus.CycCnt), 0);
    bus.BranchRel = 1'b1;
    bus.Taken     = 1'b1;
    bus.Target    = 11'(-370);
    tick();
    chk("br_taken_pc", 32'(bus.ProgCtr), 0);
    idle_inputs();

    // Not-taken branch falls through
    start_at(10'd370);
    bus.BranchRel = 1'b1;
    bus.Taken     = 1'b0;
    bus.Target    = 11'(-370);
    tick();
    chk("br_not_taken_pc", 32'(bus.ProgCtr), 371);
    idle_inputs();

    // Increment wraps at the top of memory
    jump_to(10'd1023);
    chk("jump_1023", 32'(bus.ProgCtr), 1023);
    tick();
    chk("wrap_pc", 32'(bus.ProgCtr), 0);

    // Negative branch below 0
    jump_to(10'd5);
    chk("jump_5", 32'(bus.ProgCtr), 5);
    bus.BranchRel = 1'b1;
    bus.Taken     = 1'b1;
    bus.Target    = 11'(-10);
    tick();
    idle_inputs();
`ifdef INST_FETCH_BCHK_EN
    chk("bchk_pc",      32'(bus.ProgCtr), 5);
    chk("bchk_done",    32'(bus.Done),    1);
    chk("bchk_fault",   32'(bus.Fault),   1);
    chk("bchk_running", 32'(bus.Running), 0);
`else
    chk("neg_wrap_pc",  32'(bus.ProgCtr), 1019);
    chk("neg_fault",    32'(bus.Fault),   0);
    chk("neg_running",  32'(bus.Running), 1);
`endif

    // Start clears any fault; then reset in the middle of a run
    start_at(10'd57);
    chk("s57_pc",    32'(bus.ProgCtr), 57);
    chk("s57_fault", 32'(bus.Fault),   0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_pc",      32'(bus.ProgCtr), 0);
    chk("midrst_running", 32'(bus.Running), 0);
    chk("midrst_done",    32'(bus.Done),    0);
    chk("midrst_cyc",     32'(bus.CycCnt),  0);

    // Stall beats a pending jump; counter keeps running
    start_at(10'd200);
    tick();
    chk("pre_stall_pc",  32'(bus.ProgCtr), 201);
    chk("pre_stall_cyc", 32'(bus.CycCnt),  1);
    bus.Stall    = 1'b1;
    bus.JumpAbs  = 1'b1;
    bus.JumpAddr = 10'd100;
    tick();
    tick();
    chk("stall_pc",  32'(bus.ProgCtr), 201);
    chk("stall_cyc", 32'(bus.CycCnt),  3);
    bus.Stall = 1'b0;
    tick();
    chk("unstall_pc",  32'(bus.ProgCtr), 100);
    chk("unstall_cyc", 32'(bus.CycCnt),  4);
    idle_inputs();

    // Halt at 447
    jump_to(10'd447);
    chk("j447_cyc", 32'(bus.CycCnt), 5);
    bus.Halt = 1'b1;
    tick();
    bus.Halt = 1'b0;
    chk("halt_done",    32'(bus.Done),    1);
    chk("halt_running", 32'(bus.Running), 0);
    chk("halt_pc",      32'(bus.ProgCtr), 447);
    chk("halt_cyc",     32'(bus.CycCnt),  6);
    tick();
    tick();
    chk("done_hold_pc",  32'(bus.ProgCtr), 447);
    chk("done_hold_cyc", 32'(bus.CycCnt),  6);
    chk("done_hold",     32'(bus.Done),    1);

    // Start from DONE
    start_at(10'd0);
    chk("rerun_running", 32'(bus.Running), 1);
    chk("rerun_done",    32'(bus.Done),    0);
    chk("rerun_cyc",     32'(bus.CycCnt),  0);
    chk("rerun_pc",      32'(bus.ProgCtr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
